// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg: shared states and CRC-32/IEEE helpers for the ROM byte streamer.
package rom_stream_pkg;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_TAIL, S_DONE} state_t;

    localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/stream_word_fifo.sv
// stream_word_fifo: DEPTH x 32 synchronous word FIFO with flush and same-cycle push/pop.
module stream_word_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_cnt;

    assign dout  = r_mem[r_rd];
    assign full  = r_cnt == (AW+1)'(DEPTH);
    assign empty = r_cnt == '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (push) r_wr <= r_wr + 1'b1;
            if (pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk)
        if (push) r_mem[r_wr] <= din;

endmodule

// File: rtl/rom_byte_streamer.sv
// rom_byte_streamer: buffers host words and emits a paced byte stream for the ROM loader.
// Define ROM_STREAM_CRC_EN to build the CRC-32/IEEE over emitted bytes; otherwise crc32 is 0.
module rom_byte_streamer
    import rom_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int BYTE_GAP   = 4,
    parameter bit WORD_BE    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        xfer_start,
    input  logic [24:0] xfer_len,
    input  logic        xfer_end,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        downloading,
    output logic [7:0]  indata,
    output logic        indata_clk,
    output logic [24:0] byte_count,
    output logic        overflow,
    output logic        busy,
    output logic [31:0] crc32
);
    localparam int GW = $clog2(BYTE_GAP);

    state_t        r_state, w_next;
    logic [24:0]   r_len, r_byte_count, w_next_count;
    logic [31:0]   r_shift, w_dout;
    logic [2:0]    r_lanes;
    logic [GW-1:0] r_gap;
    logic [7:0]    r_indata, w_byte;
    logic          r_end_seen, r_overflow, r_downloading, r_indata_clk;
    logic          w_start, w_emit, w_pop, w_push, w_drop, w_len_hit, w_drained, w_full, w_empty;

    assign w_start      = r_state == S_IDLE && xfer_start;
    assign w_emit       = r_state == S_STREAM && r_lanes != '0 && r_gap == '0;
    assign w_pop        = r_state == S_STREAM && r_lanes == '0 && !w_empty;
    assign w_push       = r_state == S_STREAM && wr_en && (!w_full || w_pop);
    assign w_drop       = r_state == S_STREAM && wr_en && w_full && !w_pop;
    assign w_next_count = &r_byte_count ? r_byte_count : r_byte_count + 25'd1;
    assign w_len_hit    = w_emit && r_len != '0 && w_next_count == r_len;
    assign w_drained    = r_end_seen && w_empty && r_lanes == '0;
    assign w_byte       = WORD_BE ? r_shift[31:24] : r_shift[7:0];

    stream_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  (w_start),
        .push   (w_push),
        .pop    (w_pop),
        .din    (wr_data),
        .dout   (w_dout),
        .full   (w_full),
        .empty  (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = xfer_start ? S_STREAM : S_IDLE;
            S_STREAM: w_next = (w_len_hit || w_drained) ? S_TAIL : S_STREAM;
            S_TAIL:   w_next = r_gap == '0 ? S_DONE : S_TAIL;
            default:  w_next = S_IDLE;
        endcase
    end

    // The gap counter runs from the last strobe, so it also times the tail envelope.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len         <= '0;
            r_byte_count  <= '0;
            r_shift       <= '0;
            r_lanes       <= '0;
            r_gap         <= '0;
            r_indata      <= '0;
            r_indata_clk  <= 1'b0;
            r_end_seen    <= 1'b0;
            r_overflow    <= 1'b0;
            r_downloading <= 1'b0;
        end else begin
            r_indata_clk <= w_emit;
            if (w_start) begin
                r_len         <= xfer_len;
                r_byte_count  <= '0;
                r_overflow    <= 1'b0;
                r_end_seen    <= 1'b0;
                r_lanes       <= '0;
                r_gap         <= '0;
                r_downloading <= 1'b1;
            end
            if (r_state == S_STREAM && xfer_end) r_end_seen <= 1'b1;
            if (w_drop) r_overflow <= 1'b1;
            if (w_pop) begin
                r_shift <= w_dout;
                r_lanes <= 3'd4;
            end
            if (w_emit) begin
                r_indata     <= w_byte;
                r_shift      <= WORD_BE ? r_shift << 8 : r_shift >> 8;
                r_lanes      <= w_len_hit ? 3'd0 : r_lanes - 3'd1;
                r_byte_count <= w_next_count;
                r_gap        <= GW'(BYTE_GAP - 1);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
            if (r_state == S_TAIL && r_gap == '0) r_downloading <= 1'b0;
        end
    end

`ifdef ROM_STREAM_CRC_EN
    logic [31:0] r_crc;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)    r_crc <= CRC32_INIT;
        else if (w_start) r_crc <= CRC32_INIT;
        else if (w_emit)  r_crc <= crc32_byte(r_crc, w_byte);

    assign crc32 = ~r_crc;
`else
    assign crc32 = '0;
`endif

    assign downloading = r_downloading;
    assign indata      = r_indata;
    assign indata_clk  = r_indata_clk;
    assign byte_count  = r_byte_count;
    assign overflow    = r_overflow;
    assign busy        = r_state != S_IDLE;

endmodule

// File: tb/tb_rom_byte_streamer.sv
// tb_rom_byte_streamer: table-driven transfers with a byte scoreboard plus reset and restart sequences.
module tb_rom_byte_streamer;

    logic        clk = 1'b0;
    logic        reset_n, xfer_start, xfer_end, wr_en;
    logic [24:0] xfer_len;
    logic [31:0] wr_data;
    logic        downloading, indata_clk, overflow, busy;
    logic [7:0]  indata;
    logic [24:0] byte_count;
    logic [31:0] crc32;

    always #5 clk = ~clk;

    rom_byte_streamer #(.FIFO_DEPTH(4), .BYTE_GAP(4), .WORD_BE(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .xfer_start (xfer_start),
        .xfer_len   (xfer_len),
        .xfer_end   (xfer_end),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .downloading(downloading),
        .indata     (indata),
        .indata_clk (indata_clk),
        .byte_count (byte_count),
        .overflow   (overflow),
        .busy       (busy),
        .crc32      (crc32)
    );

    typedef struct packed {
        logic [24:0]      len;
        int               nw;
        logic [5:0][31:0] w;
        int               end_at;
        int               n_acc;
        logic [24:0]      exp_cnt;
        logic             exp_ov;
        logic             chk_crc;
    } vec_t;

    int         checks = 0, errors = 0, cyc = 0, n_strobes = 0, last_cyc = -1;
    logic       prev_dl = 1'b0;
    logic [7:0] exp_q[$];
    vec_t       v[5];

`ifdef ROM_STREAM_CRC_EN
    localparam logic [31:0] EXP_CRC = 32'hCBF43926;
`else
    localparam logic [31:0] EXP_CRC = 32'h0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every strobe pops one expected byte and is checked for pacing.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) last_cyc = -1;
        else begin
            if (xfer_start && !busy) last_cyc = -1;
            if (indata_clk) begin
                n_strobes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: actual=%h required=none", indata);
                end else chk("byte", 32'(indata), 32'(exp_q.pop_front()));
                chk("dl_at_strobe", 32'(downloading), 32'd1);
                if (last_cyc >= 0) chk("spacing", 32'(cyc - last_cyc), 32'd4);
                last_cyc = cyc;
            end
            if (prev_dl && !downloading && last_cyc >= 0) chk("tail_len", 32'(cyc - last_cyc), 32'd4);
        end
        prev_dl = downloading;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [24:0] len);
        xfer_start = 1'b1;
        xfer_len   = len;
        tick();
        xfer_start = 1'b0;
        chk("start_dl", 32'(downloading), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cnt", 32'(byte_count), 32'd0);
    endtask

    task automatic write_word(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_end;
        xfer_end = 1'b1;
        tick();
        xfer_end = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        chk("leftover_bytes", 32'(exp_q.size()), 32'd0);
        chk("dl_after", 32'(downloading), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_strobes(input int target);
        int n = 0;
        while (n_strobes < target && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("strobe_timeout", 32'(n_strobes >= target), 32'd1);
    endtask

    task automatic expect_words(input vec_t t);
        int pushed = 0;
        for (int i = 0; i < t.n_acc; i++)
            for (int b = 0; b < 4; b++)
                if (t.len == '0 || pushed < int'(t.len)) begin
                    exp_q.push_back(t.w[i][31-8*b -: 8]);
                    pushed++;
                end
    endtask

    task automatic run_vec(input vec_t t);
        expect_words(t);
        start(t.len);
        for (int i = 0; i < t.nw; i++) begin
            write_word(t.w[i]);
            if (i == t.end_at) pulse_end();
        end
        wait_idle();
        chk("byte_count", 32'(byte_count), 32'(t.exp_cnt));
        chk("overflow", 32'(overflow), 32'(t.exp_ov));
        if (t.chk_crc) chk("crc32", crc32, EXP_CRC);
    endtask

    function automatic vec_t mk(input logic [24:0] len, input int nw, input int end_at, input int n_acc,
                                input logic [24:0] cnt, input logic ov, input logic c);
        vec_t t;
        t = '0;
        t.len = len; t.nw = nw; t.end_at = end_at; t.n_acc = n_acc;
        t.exp_cnt = cnt; t.exp_ov = ov; t.chk_crc = c;
        return t;
    endfunction

    initial begin
        int base;
        vec_t t;
        reset_n = 1'b0; xfer_start = 1'b0; xfer_end = 1'b0; wr_en = 1'b0;
        xfer_len = '0; wr_data = '0;
        #3;
        chk("rst_dl", 32'(downloading), 32'd0);
        chk("rst_indata", 32'(indata), 32'd0);
        chk("rst_strobe", 32'(indata_clk), 32'd0);
        chk("rst_cnt", 32'(byte_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_crc", crc32, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        v[0] = mk(25'd6, 2, -1, 2, 25'd6, 1'b0, 1'b0);
        v[0].w[0] = 32'h4E45531A; v[0].w[1] = 32'h02010000;
        v[1] = mk(25'd0, 3, 1, 3, 25'd12, 1'b0, 1'b0);
        v[1].w[0] = 32'h11223344; v[1].w[1] = 32'h55667788; v[1].w[2] = 32'h99AABBCC;
        v[2] = mk(25'd0, 6, 5, 5, 25'd20, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) v[2].w[i] = 32'hA0A1A2A3 + 32'h10101010 * i;
        v[3] = mk(25'd20, 2, 1, 2, 25'd8, 1'b0, 1'b0);
        v[3].w[0] = 32'hDEADBEEF; v[3].w[1] = 32'hCAFEF00D;
        v[4] = mk(25'd9, 3, -1, 3, 25'd9, 1'b0, 1'b1);
        v[4].w[0] = 32'h31323334; v[4].w[1] = 32'h35363738; v[4].w[2] = 32'h39000000;

        for (int k = 0; k < 5; k++) run_vec(v[k]);

        // A second xfer_start while streaming must not clear or re-arm the transfer.
        t = mk(25'd0, 3, -1, 3, 25'd12, 1'b0, 1'b0);
        t.w[0] = 32'hA1A2A3A4; t.w[1] = 32'hB1B2B3B4; t.w[2] = 32'hC1C2C3C4;
        expect_words(t);
        base = n_strobes;
        start(25'd0);
        for (int i = 0; i < 3; i++) write_word(t.w[i]);
        wait_strobes(base + 2);
        xfer_start = 1'b1;
        xfer_len   = 25'd5;
        tick();
        xfer_start = 1'b0;
        chk("restart_cnt_kept", 32'(byte_count >= 25'd2), 32'd1);
        pulse_end();
        wait_idle();
        chk("restart_byte_count", 32'(byte_count), 32'd12);

        // Reset mid-stream aborts at once and leaves no trailing strobes.
        t = mk(25'd0, 2, -1, 2, 25'd8, 1'b0, 1'b0);
        t.w[0] = 32'h01020304; t.w[1] = 32'h05060708;
        expect_words(t);
        base = n_strobes;
        start(25'd0);
        for (int i = 0; i < 2; i++) write_word(t.w[i]);
        wait_strobes(base + 3);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_dl", 32'(downloading), 32'd0);
        chk("abort_strobe", 32'(indata_clk), 32'd0);
        chk("abort_indata", 32'(indata), 32'd0);
        chk("abort_cnt", 32'(byte_count), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        base = n_strobes;
        repeat (20) tick();
        chk("no_strobe_after_reset", 32'(n_strobes - base), 32'd0);
        chk("idle_after_reset", 32'(busy), 32'd0);
        run_vec(v[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_byte_streamer.md
Name: rom_byte_streamer

Overview:
- Upstream feeder for the ROM loader.
- Accepts 32-bit words written by the host bridge during a ROM transfer and buffers them in a small word FIFO.
- Serialises the words into a paced byte stream (indata/indata_clk) with a downloading envelope, consumed directly by the iNES/FDS/NSF loader stage.
- Pacing gives the downstream SDRAM path a guaranteed minimum gap between byte writes.

Parameters:
- FIFO_DEPTH, 16: word FIFO depth; must be a power of two, at least 4.
- BYTE_GAP, 4: cycles from one indata_clk pulse to the next; minimum 2.
- WORD_BE, 1: 1 emits wr_data[31:24] first; 0 emits wr_data[7:0] first.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- xfer_start  in  1  single-cycle pulse; begins a transfer
- xfer_len  in  25  byte length, sampled on xfer_start; 0 means unknown length, terminated by xfer_end
- xfer_end  in  1  single-cycle pulse; host has written its last word
- wr_en  in  1  word write strobe, one per cycle maximum
- wr_data  in  32  word data
- downloading  out  1  transfer envelope to the loader
- indata  out  8  byte data
- indata_clk  out  1  single-cycle byte strobe
- byte_count  out  25  bytes emitted in the current transfer
- overflow  out  1  sticky; a word was dropped because the FIFO was full
- busy  out  1  high whenever state is not S_IDLE
- crc32  out  32  CRC of emitted bytes (see Optional Feature)

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All outputs 0; state S_IDLE; FIFO empty; gap counter 0; byte lane 0.
  - Asserting reset mid-transfer aborts immediately. No further strobes are issued after reset_n returns high.
- States: S_IDLE, S_STREAM, S_TAIL, S_DONE.
- S_IDLE:
  - xfer_start latches xfer_len, clears byte_count, overflow and CRC, flushes the FIFO, and goes to S_STREAM.
  - downloading rises on the cycle after xfer_start.
  - wr_en and xfer_end are ignored in S_IDLE.
- S_STREAM:
  - wr_en pushes wr_data. If the FIFO is full, the word is dropped and overflow is set. A push and a pop in the same cycle on a full FIFO is legal and not an overflow.
  - A word is popped into a 32-bit shift register when the register is empty and the FIFO is not empty.
  - A byte is emitted when the register holds data and the gap counter is 0. The emit cycle does three things:
    - indata is valid in the same cycle as indata_clk=1 and held until the next strobe.
    - byte_count increments.
    - gap counter loads BYTE_GAP-1.
  - The gap counter decrements to 0 otherwise.
  - Minimum strobe spacing is exactly BYTE_GAP cycles. Spacing is larger only when the FIFO starves.
- Termination:
  - With xfer_len != 0: after the byte where byte_count reaches xfer_len, go to S_TAIL. Remaining bytes of that word and any later words are discarded without strobes.
  - With xfer_len == 0: once xfer_end has been seen (latched) and both the FIFO and the shift register are empty, go to S_TAIL.
  - If xfer_end arrives before xfer_len is reached, keep streaming buffered data. If the FIFO empties first, go to S_TAIL; byte_count then shows the short count.
- S_TAIL:
  - downloading stays high for BYTE_GAP cycles after the last strobe, then falls.
  - The loader therefore always sees downloading=1 together with the final indata_clk.
  - Next state is S_DONE.
- S_DONE: one cycle, then S_IDLE. byte_count, overflow and crc32 hold until the next xfer_start.
- xfer_start while busy is ignored.
- wr_en outside S_STREAM is ignored and does not set overflow.
- byte_count saturates at 2^25-1 and does not wrap.

Optional Feature:
- Macro: ROM_STREAM_CRC_EN.
- Defined:
  - crc32 is CRC-32/IEEE (reflected, poly 0xEDB88320, init 0xFFFFFFFF, final XOR) over every strobed byte, updated on each indata_clk.
  - Result is valid from S_DONE onward.
- Undefined: crc32 is tied to 0 and no CRC logic is built.

Decomposition:
- Package rom_stream_pkg holds:
  - the state enum (S_IDLE, S_STREAM, S_TAIL, S_DONE);
  - CRC32_POLY and CRC32_INIT;
  - a byte-step CRC function.
- Sub-module stream_word_fifo: synchronous FIFO with FIFO_DEPTH×32 storage, full/empty flags, and simultaneous push/pop.

Test Plan:
- Length-terminated transfer, WORD_BE=1: xfer_len=6, words 0x4E45531A, 0x02010000 → strobes 4E,45,53,1A,02,01 at 4-cycle spacing; byte_count=6; last two bytes dropped; downloading falls 4 cycles after the 6th strobe.
- Unknown length with late end: xfer_len=0, 3 words, xfer_end after the 2nd word → 12 strobes; downloading stays high through the 12th strobe.
- Overflow: FIFO_DEPTH=4, 6 back-to-back wr_en with the consumer still busy → overflow=1; only the words accepted into the FIFO are strobed.
- Reset mid-stream: reset_n low after byte 3 → all outputs 0 at once; no strobe after release; a fresh transfer then works normally.
- Start while busy: a second xfer_start during S_STREAM is ignored; byte_count continues without clearing.
- CRC (ROM_STREAM_CRC_EN): bytes "123456789" → crc32=0xCBF43926 in S_DONE.
